// File: rtl/expr_gen.sv
// Random legal expression generator: E = F {op F}; F = digit | "(" digit {op digit} ")".
// Choices come from a 16-bit LFSR; one character is emitted per accepted cycle.
module expr_gen #(
   parameter bit PAREN_EN = 1'b1
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        start,
   input  logic [15:0] seed,
   input  logic [3:0]  nterms,
   input  logic        ready,
   output logic [7:0]  out,
   output logic        valid,
   output logic        last,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_FACT, S_OP, S_IDIG, S_IOP, S_CLOSE
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic [3:0]  fleft_q, fleft_d;
   logic [2:0]  ileft_q, ileft_d;

   logic        fb, par, acc;
   logic [3:0]  dval;
   logic [7:0]  dig, opc;
   logic [2:0]  nin;

   always_comb begin
      fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
      dval = (lfsr_q[3:0] >= 4'd10) ? lfsr_q[3:0] - 4'd10 : lfsr_q[3:0];
      dig  = 8'h30 + {4'h0, dval};
      opc  = lfsr_q[4] ? 8'h2A : 8'h2B;
      par  = PAREN_EN & lfsr_q[5];
      nin  = {1'b0, lfsr_q[7:6]} + 3'd1;
   end

   // Outputs depend only on held state, so they stay stable during a stall.
   always_comb begin
      valid = (state_q != S_IDLE);
      busy  = valid;
      out   = '0;
      unique case (state_q)
         S_FACT:  out = par ? 8'h28 : dig;
         S_OP:    out = opc;
         S_IDIG:  out = dig;
         S_IOP:   out = opc;
         S_CLOSE: out = 8'h29;
         default: out = '0;
      endcase
      last = valid && (fleft_q == 4'd1) &&
             (((state_q == S_FACT) && !par) || (state_q == S_CLOSE));
      acc  = valid & ready;
   end

   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      fleft_d = fleft_q;
      ileft_d = ileft_q;
      if (state_q == S_IDLE) begin
         if (start) begin
            lfsr_d  = (seed == 16'h0000) ? 16'hACE1 : seed;
            fleft_d = (nterms == 4'd0) ? 4'd1 : nterms;
            state_d = S_FACT;
         end
      end else if (acc) begin
         lfsr_d = {lfsr_q[14:0], fb};
         unique case (state_q)
            S_FACT: begin
               if (par) begin
                  ileft_d = nin;
                  state_d = S_IDIG;
               end else begin
                  fleft_d = fleft_q - 4'd1;
                  state_d = (fleft_q == 4'd1) ? S_IDLE : S_OP;
               end
            end
            S_OP:  state_d = S_FACT;
            S_IDIG: begin
               ileft_d = ileft_q - 3'd1;
               state_d = (ileft_q == 3'd1) ? S_CLOSE : S_IOP;
            end
            S_IOP: state_d = S_IDIG;
            S_CLOSE: begin
               fleft_d = fleft_q - 4'd1;
               state_d = (fleft_q == 4'd1) ? S_IDLE : S_OP;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= S_IDLE;
         lfsr_q  <= 16'hACE1;
         fleft_q <= '0;
         ileft_q <= '0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         fleft_q <= fleft_d;
         ileft_q <= ileft_d;
      end
   end

endmodule

// File: tb/tb_expr_gen.sv
// Directed and random checks of expr_gen against a grammar-walking reference
// model whose expected characters are queued at start and popped on each accept.
module tb_expr_gen;

   logic        clk = 1'b0;
   logic        clr, start, ready;
   logic [15:0] seed;
   logic [3:0]  nterms;
   logic [7:0]  out;
   logic        valid, last, busy;

   int unsigned passed = 0;
   int unsigned total  = 0;
   int unsigned fails  = 0;

   logic [8:0]  exp_q[$];   // {last, char}
   logic [7:0]  got_q[$];
   logic [7:0]  ref_q[$];

   always #5 clk = ~clk;

   expr_gen #(.PAREN_EN(1'b1)) dut (
      .clk(clk), .clr(clr), .start(start), .seed(seed), .nterms(nterms),
      .ready(ready), .out(out), .valid(valid), .last(last), .busy(busy)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] step(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   function automatic logic [7:0] mdig(input logic [15:0] l);
      int v;
      v = int'(l[3:0]);
      if (v >= 10) v -= 10;
      return 8'(8'h30 + v);
   endfunction

   function automatic logic [7:0] mop(input logic [15:0] l);
      return l[4] ? "*" : "+";
   endfunction

   function automatic bit legal(input logic [7:0] c);
      return (c >= "0" && c <= "9") || c == "+" || c == "*" || c == "(" || c == ")";
   endfunction

   // Walks the grammar directly; the LFSR advances once per emitted character.
   task automatic model(input logic [15:0] s, input logic [3:0] n);
      logic [15:0] l;
      int nf, k;
      l  = (s == 16'h0000) ? 16'hACE1 : s;
      nf = (n == 4'd0) ? 1 : int'(n);
      for (int f = 0; f < nf; f++) begin
         if (f > 0) begin exp_q.push_back({1'b0, mop(l)}); l = step(l); end
         if (l[5]) begin
            k = int'(l[7:6]) + 1;
            exp_q.push_back({1'b0, 8'h28}); l = step(l);
            for (int i = 0; i < k; i++) begin
               if (i > 0) begin exp_q.push_back({1'b0, mop(l)}); l = step(l); end
               exp_q.push_back({1'b0, mdig(l)}); l = step(l);
            end
            exp_q.push_back({f == nf - 1, 8'h29}); l = step(l);
         end else begin
            exp_q.push_back({f == nf - 1, mdig(l)}); l = step(l);
         end
      end
   endtask

   task automatic pulse_start(input logic [15:0] s, input logic [3:0] n);
      exp_q.delete();
      got_q.delete();
      model(s, n);
      @(negedge clk);
      seed = s; nterms = n; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Consume the stream at negedges; optional stall, clr or busy-start at a char index.
   task automatic drain(input int stall_at, input int clr_at, input int start_at);
      int idx, budget;
      logic [7:0] so;
      logic sv, sl;
      idx = 0; budget = 0;
      while (exp_q.size() > 0 && budget < 300) begin
         budget++;
         check("valid", 16'(valid), 16'd1);
         check("out", 16'(out), 16'(exp_q[0][7:0]));
         check("last", 16'(last), 16'(exp_q[0][8]));
         check("charset", 16'(legal(out)), 16'd1);
         if (idx == clr_at) begin
            clr = 1'b1;
            @(negedge clk);
            clr = 1'b0;
            check("clr_valid", 16'(valid), 16'd0);
            check("clr_busy", 16'(busy), 16'd0);
            check("clr_out", 16'(out), 16'h00);
            exp_q.delete();
            return;
         end
         if (idx == stall_at) begin
            so = out; sv = valid; sl = last;
            ready = 1'b0;
            repeat (5) begin
               @(negedge clk);
               check("stall_out", 16'(out), 16'(so));
               check("stall_valid", 16'(valid), 16'(sv));
               check("stall_last", 16'(last), 16'(sl));
            end
            ready = 1'b1;
         end
         got_q.push_back(out);
         void'(exp_q.pop_front());
         if (idx == start_at) begin seed = 16'h1234; nterms = 4'd9; start = 1'b1; end
         @(negedge clk);
         start = 1'b0;
         idx++;
      end
      check("stream_done", 16'(exp_q.size()), 16'd0);
      check("end_valid", 16'(valid), 16'd0);
      check("end_busy", 16'(busy), 16'd0);
   endtask

   initial begin
      clr = 1'b1; start = 1'b0; ready = 1'b1; seed = '0; nterms = '0;
      repeat (3) @(negedge clk);
      check("rst_out", 16'(out), 16'h00);
      check("rst_valid", 16'(valid), 16'd0);
      check("rst_last", 16'(last), 16'd0);
      check("rst_busy", 16'(busy), 16'd0);

      // clr and start together: clr wins
      start = 1'b1; seed = 16'h0001; nterms = 4'd3;
      @(negedge clk);
      start = 1'b0; clr = 1'b0;
      check("clr_start_busy", 16'(busy), 16'd0);

      // T1: single digit "1"
      pulse_start(16'h0001, 4'd1);
      check("t1_out", 16'(out), 16'h31);
      check("t1_last", 16'(last), 16'd1);
      drain(-1, -1, -1);

      // T2: "(0)"
      pulse_start(16'h0020, 4'd1);
      check("t2_open", 16'(out), 16'h28);
      check("t2_open_last", 16'(last), 16'd0);
      drain(-1, -1, -1);
      check("t2_len", 16'(got_q.size()), 16'd3);
      if (got_q.size() == 3) begin
         check("t2_dig", 16'(got_q[1]), 16'h30);
         check("t2_close", 16'(got_q[2]), 16'h29);
      end

      // T3: zero seed behaves as ACE1
      pulse_start(16'h0000, 4'd6);
      drain(-1, -1, -1);
      ref_q = got_q;
      pulse_start(16'hACE1, 4'd6);
      drain(-1, -1, -1);
      check("t3_len", 16'(got_q.size()), 16'(ref_q.size()));
      for (int i = 0; i < ref_q.size() && i < got_q.size(); i++)
         check("t3_char", 16'(got_q[i]), 16'(ref_q[i]));

      // T4: stall mid-stream
      pulse_start(16'hBEEF, 4'd5);
      drain(3, -1, -1);

      // nterms=0 means one factor; nterms=15 is the longest
      pulse_start(16'h5A5A, 4'd0);
      drain(-1, -1, -1);
      pulse_start(16'h7777, 4'd15);
      drain(-1, -1, -1);

      // T6: clr on the 3rd character, then start while busy is ignored
      pulse_start(16'h0001, 4'd4);
      drain(-1, 2, -1);
      pulse_start(16'h0003, 4'd4);
      drain(-1, -1, 1);

      // T5: random seeds and lengths
      for (int n = 0; n < 1000; n++) begin
         pulse_start(16'($urandom), 4'($urandom_range(0, 15)));
         drain(-1, -1, -1);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
